// File: rtl/utils_pkg.sv
// Shared utility definitions: counter terminal-handling modes and a range clamp.
package utils_pkg;

  // Terminal handling modes for counters: wrap to the opposite bound or clamp.
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Clamp an unsigned value into [lo, hi]; callers zero-extend narrower values.
  function automatic logic [31:0] clamp_u32(input logic [31:0] value,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (value < lo) begin
      return lo;
    end
    if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescale counter: emits a step strobe on every PRESCALE-th enabled cycle.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic step
);

  // A single-bit counter is kept even for PRESCALE == 1; it simply stays at 0.
  localparam int unsigned    PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $fatal(1, "counter_prescaler: PRESCALE must be in 1..65535");
  end

  logic [PW-1:0] pre_cnt_p0;

  assign step = enable && (pre_cnt_p0 == LAST);

  // Advance on enabled cycles, wrap to 0 after the step cycle, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      pre_cnt_p0 <= '0;
    end else if (enable) begin
      pre_cnt_p0 <= step ? '0 : pre_cnt_p0 + PW'(1);
    end
  end

endmodule

// File: rtl/counter_multimode.sv
// Up/down counter with prescaler, sync clear/load, programmable bounds and
// wrap-or-saturate terminal handling.
module counter_multimode
  import utils_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  START_VALUE = WIDTH'('h0F),
  parameter logic [WIDTH-1:0]  STEP        = WIDTH'(1),
  parameter logic [WIDTH-1:0]  MIN_VALUE   = '0,
  parameter logic [WIDTH-1:0]  MAX_VALUE   = '1,
  parameter logic              SATURATE    = CNT_WRAP,
  parameter int unsigned       PRESCALE    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             bound_pulse,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter_multimode: WIDTH must be in 2..32");
  end
  if (MAX_VALUE <= MIN_VALUE) begin : g_bad_bounds
    $fatal(1, "counter_multimode: MAX_VALUE must exceed MIN_VALUE");
  end
  if (START_VALUE < MIN_VALUE || START_VALUE > MAX_VALUE) begin : g_bad_start
    $fatal(1, "counter_multimode: START_VALUE outside [MIN_VALUE, MAX_VALUE]");
  end
  if (STEP < 1 || STEP > (MAX_VALUE - MIN_VALUE)) begin : g_bad_step
    $fatal(1, "counter_multimode: STEP must be in 1..MAX_VALUE-MIN_VALUE");
  end

  // One step of the counter, done one bit wider than the count so the bound
  // tests cannot overflow. Returns {bound_hit, next_count}.
  function automatic logic [WIDTH:0] step_next(input logic [WIDTH-1:0] cur,
                                               input logic             up);
    logic        [WIDTH:0] sum;
    logic signed [WIDTH:0] diff;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, STEP};
      if (sum <= {1'b0, MAX_VALUE}) begin
        return {1'b0, sum[WIDTH-1:0]};
      end
      if (SATURATE == CNT_SAT) begin
        return {cur != MAX_VALUE, MAX_VALUE};
      end
      return {1'b1, MIN_VALUE};
    end
    diff = $signed({1'b0, cur}) - $signed({1'b0, STEP});
    if (diff >= $signed({1'b0, MIN_VALUE})) begin
      return {1'b0, diff[WIDTH-1:0]};
    end
    if (SATURATE == CNT_SAT) begin
      return {cur != MIN_VALUE, MIN_VALUE};
    end
    return {1'b1, MAX_VALUE};
  endfunction

  // Load values outside the programmed range are pulled onto the nearest bound.
  function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
    return WIDTH'(clamp_u32(32'(v), 32'(MIN_VALUE), 32'(MAX_VALUE)));
  endfunction

  logic             step_cycle;
  logic [WIDTH:0]   nxt;
  logic [WIDTH-1:0] count_p0;
  logic             step_p0;
  logic             bound_p0;

  // Clear and load both restart the prescale window.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .restart (clear || load),
    .enable  (enable),
    .step    (step_cycle)
  );

  assign nxt = step_next(count_p0, up_down);

  // ---- stage p0: count and event pulses, priority reset > clear > load > step
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_p0 <= START_VALUE;
      step_p0  <= 1'b0;
      bound_p0 <= 1'b0;
    end else if (load) begin
      count_p0 <= load_clamp(load_value);
      step_p0  <= 1'b0;
      bound_p0 <= 1'b0;
    end else if (step_cycle) begin
      count_p0 <= nxt[WIDTH-1:0];
      step_p0  <= 1'b1;
      bound_p0 <= nxt[WIDTH];
    end else begin
      step_p0  <= 1'b0;
      bound_p0 <= 1'b0;
    end
  end

  assign count       = count_p0;
  assign step_pulse  = step_p0;
  assign bound_pulse = bound_p0;
  assign at_max      = (count_p0 == MAX_VALUE);
  assign at_min      = (count_p0 == MIN_VALUE);

endmodule

// File: tb/tb_counter_multimode.sv
// Directed bench: four counter configurations driven through hand-computed steps.
module tb_counter_multimode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // d: defaults, w: wrap 0..9 step 3, s: saturate 2..0xC8 step 4, p: prescale 3
  logic       rst_d, en_d, ud_d, clr_d, ld_d, stp_d, bnd_d, amx_d, amn_d;
  logic [7:0] lv_d, cnt_d;
  logic       rst_w, en_w, ud_w, clr_w, ld_w, stp_w, bnd_w, amx_w, amn_w;
  logic [7:0] lv_w, cnt_w;
  logic       rst_s, en_s, ud_s, clr_s, ld_s, stp_s, bnd_s, amx_s, amn_s;
  logic [7:0] lv_s, cnt_s;
  logic       rst_p, en_p, ud_p, clr_p, ld_p, stp_p, bnd_p, amx_p, amn_p;
  logic [7:0] lv_p, cnt_p;

  counter_multimode #(.WIDTH(8)) u_def (
    .clock(clk), .reset(rst_d), .enable(en_d), .up_down(ud_d), .clear(clr_d),
    .load(ld_d), .load_value(lv_d), .count(cnt_d), .step_pulse(stp_d),
    .bound_pulse(bnd_d), .at_max(amx_d), .at_min(amn_d)
  );

  counter_multimode #(.WIDTH(8), .START_VALUE(8'd0), .STEP(8'd3),
                      .MIN_VALUE(8'd0), .MAX_VALUE(8'd9)) u_wrap (
    .clock(clk), .reset(rst_w), .enable(en_w), .up_down(ud_w), .clear(clr_w),
    .load(ld_w), .load_value(lv_w), .count(cnt_w), .step_pulse(stp_w),
    .bound_pulse(bnd_w), .at_max(amx_w), .at_min(amn_w)
  );

  counter_multimode #(.WIDTH(8), .START_VALUE(8'd5), .STEP(8'd4),
                      .MIN_VALUE(8'd2), .MAX_VALUE(8'hC8), .SATURATE(1'b1)) u_sat (
    .clock(clk), .reset(rst_s), .enable(en_s), .up_down(ud_s), .clear(clr_s),
    .load(ld_s), .load_value(lv_s), .count(cnt_s), .step_pulse(stp_s),
    .bound_pulse(bnd_s), .at_max(amx_s), .at_min(amn_s)
  );

  counter_multimode #(.WIDTH(8), .PRESCALE(3)) u_pre (
    .clock(clk), .reset(rst_p), .enable(en_p), .up_down(ud_p), .clear(clr_p),
    .load(ld_p), .load_value(lv_p), .count(cnt_p), .step_pulse(stp_p),
    .bound_pulse(bnd_p), .at_max(amx_p), .at_min(amn_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int wrap_cnt[5] = '{0, 3, 6, 9, 0};
  int wrap_bnd[5] = '{1, 0, 0, 0, 1};
  int pre_en[4]   = '{1, 0, 1, 1};
  int pre_cnt[4]  = '{8'h0F, 8'h0F, 8'h0F, 8'h10};
  int pre_stp[4]  = '{0, 0, 0, 1};

  initial begin
    {rst_d, en_d, ud_d, clr_d, ld_d} = 5'b10100; lv_d = '0;
    {rst_w, en_w, ud_w, clr_w, ld_w} = 5'b10100; lv_w = '0;
    {rst_s, en_s, ud_s, clr_s, ld_s} = 5'b10100; lv_s = '0;
    {rst_p, en_p, ud_p, clr_p, ld_p} = 5'b10100; lv_p = '0;
    tick();
    tick();
    // ---- reset state
    chk("rst_count_d", cnt_d, 8'h0F);
    chk("rst_step_d", stp_d, 0);
    chk("rst_bound_d", bnd_d, 0);
    chk("rst_atmax_d", amx_d, 0);
    chk("rst_atmin_d", amn_d, 0);
    chk("rst_count_w", cnt_w, 0);
    chk("rst_atmin_w", amn_w, 1);
    chk("rst_count_s", cnt_s, 5);
    chk("rst_count_p", cnt_p, 8'h0F);
    rst_d = 0; rst_w = 0; rst_s = 0; rst_p = 0;

    // ---- default instance: plain counting
    en_d = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("up_count_d", cnt_d, 8'h0F + i);
      chk("up_step_d", stp_d, 1);
      chk("up_bound_d", bnd_d, 0);
    end
    // load 0x40, one more step, then reset together with a load
    en_d = 0; ld_d = 1; lv_d = 8'h40;
    tick();
    chk("load40_d", cnt_d, 8'h40);
    chk("load40_step_d", stp_d, 0);
    ld_d = 0; en_d = 1;
    tick();
    chk("step41_d", cnt_d, 8'h41);
    rst_d = 1; ld_d = 1; lv_d = 8'h77;
    tick();
    chk("rst_mid_count_d", cnt_d, 8'h0F);
    chk("rst_mid_step_d", stp_d, 0);
    chk("rst_mid_bound_d", bnd_d, 0);
    rst_d = 0; ld_d = 0;
    // clear + load + step in one cycle
    en_d = 0; ld_d = 1; lv_d = 8'h30;
    tick();
    clr_d = 1; ld_d = 1; lv_d = 8'h55; en_d = 1;
    tick();
    chk("prio_count_d", cnt_d, 8'h0F);
    chk("prio_step_d", stp_d, 0);
    clr_d = 0; ld_d = 0; en_d = 0;
    // wrap at the full-width bounds
    ld_d = 1; lv_d = 8'hFF;
    tick();
    chk("loadff_d", cnt_d, 8'hFF);
    chk("loadff_atmax_d", amx_d, 1);
    ld_d = 0; en_d = 1; ud_d = 1;
    tick();
    chk("wrap_up_count_d", cnt_d, 8'h00);
    chk("wrap_up_bound_d", bnd_d, 1);
    chk("wrap_up_atmin_d", amn_d, 1);
    ud_d = 0;
    tick();
    chk("wrap_dn_count_d", cnt_d, 8'hFF);
    chk("wrap_dn_bound_d", bnd_d, 1);
    en_d = 0;

    // ---- wrap instance: 9 -> 0, 3, 6, 9, 0
    ld_w = 1; lv_w = 8'd9;
    tick();
    chk("load9_w", cnt_w, 9);
    chk("load9_atmax_w", amx_w, 1);
    ld_w = 0; en_w = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap_count_w", cnt_w, wrap_cnt[i]);
      chk("wrap_bound_w", bnd_w, wrap_bnd[i]);
      chk("wrap_step_w", stp_w, 1);
    end
    en_w = 0;

    // ---- saturate instance
    en_s = 1; ud_s = 0;
    tick();
    chk("sat_dn_count_s", cnt_s, 2);
    chk("sat_dn_bound_s", bnd_s, 1);
    chk("sat_dn_step_s", stp_s, 1);
    tick();
    chk("sat_hold_count_s", cnt_s, 2);
    chk("sat_hold_bound_s", bnd_s, 0);
    chk("sat_hold_step_s", stp_s, 1);
    chk("sat_hold_atmin_s", amn_s, 1);
    en_s = 0; ld_s = 1; lv_s = 8'hFF;
    tick();
    chk("clamp_hi_s", cnt_s, 8'hC8);
    chk("clamp_hi_atmax_s", amx_s, 1);
    ld_s = 0; en_s = 1; ud_s = 1;
    tick();
    chk("sat_up_count_s", cnt_s, 8'hC8);
    chk("sat_up_bound_s", bnd_s, 0);
    chk("sat_up_step_s", stp_s, 1);
    en_s = 0; ld_s = 1; lv_s = 8'h00;
    tick();
    chk("clamp_lo_s", cnt_s, 2);
    lv_s = 8'h10;
    tick();
    ld_s = 0; en_s = 1; ud_s = 0;
    tick();
    chk("plain_dn_count_s", cnt_s, 8'h0C);
    chk("plain_dn_bound_s", bnd_s, 0);
    en_s = 0;

    // ---- prescale instance: enable 1,0,1,1 gives one step
    for (int i = 0; i < 4; i++) begin
      en_p = pre_en[i][0];
      tick();
      chk("pre_count_p", cnt_p, pre_cnt[i]);
      chk("pre_step_p", stp_p, pre_stp[i]);
    end
    en_p = 1;
    tick();
    chk("pre_part_p", cnt_p, 8'h10);
    clr_p = 1;
    tick();
    chk("pre_clear_p", cnt_p, 8'h0F);
    clr_p = 0;
    tick();
    chk("pre_after_clr1_p", cnt_p, 8'h0F);
    tick();
    chk("pre_after_clr2_p", cnt_p, 8'h0F);
    tick();
    chk("pre_after_clr3_p", cnt_p, 8'h10);
    chk("pre_after_clr3_step_p", stp_p, 1);
    // direction changes on non-step cycles are ignored
    ud_p = 0;
    tick();
    tick();
    chk("pre_ud_hold_p", cnt_p, 8'h10);
    ud_p = 1;
    tick();
    chk("pre_ud_sample_p", cnt_p, 8'h11);
    // reset mid-prescale discards the partial window
    tick();
    tick();
    rst_p = 1;
    tick();
    chk("pre_rst_p", cnt_p, 8'h0F);
    rst_p = 0;
    tick();
    tick();
    chk("pre_rst_window_p", cnt_p, 8'h0F);
    chk("pre_rst_window_step_p", stp_p, 0);
    tick();
    chk("pre_rst_step_p", cnt_p, 8'h10);
    en_p = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
